pixel_packer: RTL and testbench

PIXEL_PACKER -- requirements
Module: pixel_packer

---
 rtl/pixel_packer.sv | 191 +++++++++++++++++++
 tb/tb_pixel_packer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/pixel_packer.sv
// pixel_packer: binarises a pixel stream against a threshold and packs the
// resulting bits MSB-first into PACK_W-bit words with a valid/ready output.
// Frames are delimited by iFVAL; a trailing partial word is zero-padded and
// emitted when the frame ends.
// Optional feature macro: PIXEL_PACKER_LINE_FLUSH_EN -- when defined, each
// iLVAL falling edge also flushes a partial word so every line starts
// word-aligned.
module pixel_packer #(
  parameter int PIX_W  = 12,
  parameter int PACK_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic [PIX_W-1:0]  iDATA,
  input  logic              iDVAL,
  input  logic              iLVAL,
  input  logic              iFVAL,
  input  logic [PIX_W-1:0]  iTHRESH,
  input  logic              iINVERT,
  output logic [PACK_W-1:0] oDATA,
  output logic              oVALID,
  input  logic              iREADY,
  output logic [CNT_W-1:0]  oWORD_CNT,
  output logic [15:0]       oFRAME_CNT,
  output logic              oOVF
);

  localparam int FILL_W = $clog2(PACK_W + 1);
  localparam logic [FILL_W-1:0] FULL = FILL_W'(PACK_W);

  typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH} state_t;

  state_t              state;
  logic                fval_d;
  logic                pend_rise;
  logic [PACK_W-1:0]   sreg;
  logic [FILL_W-1:0]   fill;

  logic                pix_bit;
  logic                fval_rise;
  logic                fval_fall;
  logic                enter_active;
  logic                accept;
  logic                transfer;
  logic [PACK_W-1:0]   acc_sreg;
  logic [FILL_W-1:0]   acc_fill;
  logic [PACK_W-1:0]   cur_sreg;
  logic [FILL_W-1:0]   cur_fill;
  logic [PACK_W-1:0]   next_sreg;
  logic [FILL_W-1:0]   next_fill;
  logic                word_done;
  logic [PACK_W-1:0]   word_val;

  assign pix_bit      = (iDATA > iTHRESH) ^ iINVERT;
  assign fval_rise    = iFVAL & ~fval_d;
  assign fval_fall    = ~iFVAL & fval_d;
  assign enter_active = (state == IDLE) && (fval_rise || pend_rise);
  assign accept       = (state == ACTIVE) && iDVAL;
  assign transfer     = oVALID && iREADY;
  assign acc_sreg     = {sreg[PACK_W-2:0], pix_bit};
  assign acc_fill     = fill + FILL_W'(1);

`ifdef PIXEL_PACKER_LINE_FLUSH_EN
  logic lval_d;
  logic lval_fall;
  assign lval_fall = ~iLVAL & lval_d;

  // Remember the previous line-valid level to spot the end of each line
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) lval_d <= 1'b0;
    else      lval_d <= iLVAL;
  end
`else
  logic unused_lval;
  assign unused_lval = iLVAL;
`endif

  // Decide the next shift-register contents and whether a word is finished
  always_comb begin
    cur_sreg  = sreg;
    cur_fill  = fill;
    next_sreg = sreg;
    next_fill = fill;
    word_done = 1'b0;
    word_val  = '0;
    if (enter_active) begin
      next_sreg = '0;
      next_fill = '0;
    end else if (state == ACTIVE) begin
      if (accept) begin
        cur_sreg = acc_sreg;
        cur_fill = acc_fill;
      end
      if (accept && (acc_fill == FULL)) begin
        word_done = 1'b1;
        word_val  = acc_sreg;
        next_sreg = '0;
        next_fill = '0;
`ifdef PIXEL_PACKER_LINE_FLUSH_EN
      end else if (lval_fall && (cur_fill != '0)) begin
        word_done = 1'b1;
        word_val  = cur_sreg << (FULL - cur_fill);
        next_sreg = '0;
        next_fill = '0;
`endif
      end else begin
        next_sreg = cur_sreg;
        next_fill = cur_fill;
      end
    end else if (state == FLUSH) begin
      if (fill != '0) begin
        word_done = 1'b1;
        word_val  = sreg << (FULL - fill);
      end
      next_sreg = '0;
      next_fill = '0;
    end
  end

  // Frame sequencing: wait for a frame, pack it, then flush the tail
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state     <= IDLE;
      fval_d    <= 1'b0;
      pend_rise <= 1'b0;
    end else begin
      fval_d <= iFVAL;
      unique case (state)
        IDLE: begin
          pend_rise <= 1'b0;
          if (enter_active) state <= ACTIVE;
        end
        ACTIVE: begin
          if (fval_fall) state <= FLUSH;
        end
        FLUSH: begin
          pend_rise <= fval_rise;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Shift register and fill count for the word being assembled
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      sreg <= '0;
      fill <= '0;
    end else begin
      sreg <= next_sreg;
      fill <= next_fill;
    end
  end

  // Output word holding register; a word arriving while one is stuck is lost
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      oDATA  <= '0;
      oVALID <= 1'b0;
      oOVF   <= 1'b0;
    end else begin
      if (word_done) begin
        if (!oVALID || iREADY) begin
          oDATA  <= word_val;
          oVALID <= 1'b1;
        end else begin
          oOVF <= 1'b1;
        end
      end else if (transfer) begin
        oVALID <= 1'b0;
      end
      if (enter_active) oOVF <= 1'b0;
    end
  end

  // Per-frame accepted-word count and free-running frame count
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      oWORD_CNT  <= '0;
      oFRAME_CNT <= '0;
    end else if (enter_active) begin
      oWORD_CNT  <= '0;
      oFRAME_CNT <= oFRAME_CNT + 16'd1;
    end else if (transfer && (oWORD_CNT != '1)) begin
      oWORD_CNT <= oWORD_CNT + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pixel_packer.sv
// tb_pixel_packer: directed test of pixel_packer in its default build
// (PACK_W=16, PIX_W=12, line flush disabled).
module tb_pixel_packer;

  logic        iCLK = 1'b0;
  logic        iRST;
  logic [11:0] iDATA;
  logic        iDVAL;
  logic        iLVAL;
  logic        iFVAL;
  logic [11:0] iTHRESH;
  logic        iINVERT;
  logic [15:0] oDATA;
  logic        oVALID;
  logic        iREADY;
  logic [15:0] oWORD_CNT;
  logic [15:0] oFRAME_CNT;
  logic        oOVF;

  int checkCount = 0;
  int passCount  = 0;

  pixel_packer #(.PIX_W(12), .PACK_W(16), .CNT_W(16)) dut (
    .iCLK      (iCLK),
    .iRST      (iRST),
    .iDATA     (iDATA),
    .iDVAL     (iDVAL),
    .iLVAL     (iLVAL),
    .iFVAL     (iFVAL),
    .iTHRESH   (iTHRESH),
    .iINVERT   (iINVERT),
    .oDATA     (oDATA),
    .oVALID    (oVALID),
    .iREADY    (iREADY),
    .oWORD_CNT (oWORD_CNT),
    .oFRAME_CNT(oFRAME_CNT),
    .oOVF      (oOVF)
  );

  // 100 MHz free-running clock
  always #5 iCLK = ~iCLK;

  // Drive one cycle of pixel inputs, then step to just after the next edge
  task automatic applyStimulus(input logic [11:0] data, input logic dval);
    iDATA = data;
    iDVAL = dval;
    @(posedge iCLK);
    #1;
  endtask

  // Feed n valid pixels alternating between a and b, starting with a
  task automatic pushPixels(input int n, input logic [11:0] a, input logic [11:0] b);
    for (int i = 0; i < n; i++) applyStimulus((i % 2 == 0) ? a : b, 1'b1);
    iDVAL = 1'b0;
  endtask

  // Compare one observed value against its expected value
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
  endtask

  // Start a frame: one cycle with iFVAL high
  task automatic startFrame();
    iFVAL = 1'b1;
    applyStimulus(12'd0, 1'b0);
  endtask

  // End a frame and let FLUSH and IDLE pass
  task automatic endFrame();
    iFVAL = 1'b0;
    repeat (3) applyStimulus(12'd0, 1'b0);
  endtask

  // Directed sequence
  initial begin
    iRST = 1'b1; iDATA = '0; iDVAL = 1'b0; iLVAL = 1'b0; iFVAL = 1'b0;
    iTHRESH = 12'd100; iINVERT = 1'b0; iREADY = 1'b1;
    #1;
    checkOutput("rst_data",  32'(oDATA), 32'h0);
    checkOutput("rst_valid", 32'(oVALID), 32'h0);
    checkOutput("rst_frame", 32'(oFRAME_CNT), 32'h0);
    checkOutput("rst_wcnt",  32'(oWORD_CNT), 32'h0);
    checkOutput("rst_ovf",   32'(oOVF), 32'h0);
    repeat (2) applyStimulus(12'd0, 1'b0);
    iRST = 1'b0;
    repeat (2) applyStimulus(12'd0, 1'b0);

    // Frame 1: alternating 200/50 -> AAAA
    startFrame();
    checkOutput("f1_frame", 32'(oFRAME_CNT), 32'd1);
    pushPixels(15, 12'd200, 12'd50);
    checkOutput("f1_not_yet", 32'(oVALID), 32'h0);
    applyStimulus(12'd50, 1'b1);
    checkOutput("f1_valid", 32'(oVALID), 32'h1);
    checkOutput("f1_data",  32'(oDATA), 32'hAAAA);
    checkOutput("f1_wcnt0", 32'(oWORD_CNT), 32'd0);
    applyStimulus(12'd0, 1'b0);
    checkOutput("f1_wcnt1", 32'(oWORD_CNT), 32'd1);
    checkOutput("f1_drain", 32'(oVALID), 32'h0);
    endFrame();
    checkOutput("f1_noflush", 32'(oVALID), 32'h0);

    // Frame 2: same pixels inverted -> 5555
    iINVERT = 1'b1;
    startFrame();
    checkOutput("f2_frame", 32'(oFRAME_CNT), 32'd2);
    checkOutput("f2_wcnt_clr", 32'(oWORD_CNT), 32'd0);
    pushPixels(16, 12'd200, 12'd50);
    checkOutput("f2_data", 32'(oDATA), 32'h5555);
    applyStimulus(12'd0, 1'b0);
    checkOutput("f2_wcnt", 32'(oWORD_CNT), 32'd1);
    endFrame();
    iINVERT = 1'b0;

    // Frame 3: backpressure, second word dropped
    iREADY = 1'b0;
    startFrame();
    pushPixels(16, 12'd4095, 12'd4095);
    checkOutput("f3_valid1", 32'(oVALID), 32'h1);
    checkOutput("f3_data1",  32'(oDATA), 32'hFFFF);
    checkOutput("f3_ovf0",   32'(oOVF), 32'h0);
    pushPixels(16, 12'd4095, 12'd4095);
    checkOutput("f3_hold", 32'(oDATA), 32'hFFFF);
    checkOutput("f3_ovf1", 32'(oOVF), 32'h1);
    checkOutput("f3_wcnt0", 32'(oWORD_CNT), 32'd0);
    iREADY = 1'b1;
    applyStimulus(12'd0, 1'b0);
    checkOutput("f3_wcnt1", 32'(oWORD_CNT), 32'd1);
    checkOutput("f3_drain", 32'(oVALID), 32'h0);
    checkOutput("f3_ovf_sticky", 32'(oOVF), 32'h1);
    endFrame();
    checkOutput("f3_nothing_left", 32'(oVALID), 32'h0);

    // Frame 4: 5-pixel partial flushed at frame end
    iREADY = 1'b0;
    startFrame();
    checkOutput("f4_frame", 32'(oFRAME_CNT), 32'd4);
    checkOutput("f4_ovf_clr", 32'(oOVF), 32'h0);
    pushPixels(5, 12'd4095, 12'd4095);
    iFVAL = 1'b0;
    applyStimulus(12'd0, 1'b0);
    checkOutput("f4_pre_flush", 32'(oVALID), 32'h0);
    applyStimulus(12'd0, 1'b0);
    checkOutput("f4_flush_valid", 32'(oVALID), 32'h1);
    checkOutput("f4_flush_data",  32'(oDATA), 32'hF800);
    applyStimulus(12'd0, 1'b0);
    checkOutput("f4_flush_hold", 32'(oDATA), 32'hF800);
    iREADY = 1'b1;
    applyStimulus(12'd0, 1'b0);
    checkOutput("f4_taken", 32'(oVALID), 32'h0);
    checkOutput("f4_wcnt", 32'(oWORD_CNT), 32'd1);
    applyStimulus(12'd0, 1'b0);
    checkOutput("f4_once", 32'(oVALID), 32'h0);

    // Frame 5: 40 pixels packed across lines, tail FF00 at frame end
    startFrame();
    checkOutput("f5_frame", 32'(oFRAME_CNT), 32'd5);
    checkOutput("f5_wcnt_clr", 32'(oWORD_CNT), 32'd0);
    pushPixels(16, 12'd4095, 12'd4095);
    checkOutput("f5_w1", 32'(oDATA), 32'hFFFF);
    pushPixels(1, 12'd4095, 12'd4095);
    checkOutput("f5_w1_taken", 32'(oWORD_CNT), 32'd1);
    pushPixels(15, 12'd4095, 12'd4095);
    checkOutput("f5_w2_valid", 32'(oVALID), 32'h1);
    checkOutput("f5_w2", 32'(oDATA), 32'hFFFF);
    pushPixels(1, 12'd4095, 12'd4095);
    checkOutput("f5_w2_taken", 32'(oWORD_CNT), 32'd2);
    pushPixels(7, 12'd4095, 12'd4095);
    checkOutput("f5_no_word_yet", 32'(oVALID), 32'h0);
    // frame falls, then rises again while in FLUSH
    iFVAL = 1'b0;
    applyStimulus(12'd0, 1'b0);
    iFVAL = 1'b1;
    applyStimulus(12'd0, 1'b0);
    checkOutput("f5_tail_valid", 32'(oVALID), 32'h1);
    checkOutput("f5_tail_data",  32'(oDATA), 32'hFF00);
    checkOutput("f5_still_f5", 32'(oFRAME_CNT), 32'd5);
    applyStimulus(12'd0, 1'b0);
    checkOutput("f6_frame", 32'(oFRAME_CNT), 32'd6);
    checkOutput("f6_wcnt_clr", 32'(oWORD_CNT), 32'd0);

    // Frame 6: reset after 7 pixels
    pushPixels(7, 12'd4095, 12'd4095);
    iRST = 1'b1;
    iFVAL = 1'b0;
    #1;
    checkOutput("mid_rst_data",  32'(oDATA), 32'h0);
    checkOutput("mid_rst_frame", 32'(oFRAME_CNT), 32'h0);
    checkOutput("mid_rst_valid", 32'(oVALID), 32'h0);
    applyStimulus(12'd0, 1'b0);
    iRST = 1'b0;
    repeat (3) applyStimulus(12'd0, 1'b0);
    checkOutput("post_rst_no_partial", 32'(oVALID), 32'h0);

    // New frame after reset: 101/100 around threshold 100 -> AAAA
    startFrame();
    checkOutput("pr_frame", 32'(oFRAME_CNT), 32'd1);
    pushPixels(15, 12'd101, 12'd100);
    checkOutput("pr_aligned", 32'(oVALID), 32'h0);
    applyStimulus(12'd100, 1'b1);
    iDVAL = 1'b0;
    checkOutput("pr_valid", 32'(oVALID), 32'h1);
    checkOutput("pr_data", 32'(oDATA), 32'hAAAA);
    endFrame();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
